fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Forwarding and hazard control for the execute stage. Tracks destination registers of in-flight instructions in a 3-slot shadow pipeline (EX, MEM, WB), and registers 3-bit operand-select codes for the two `mux6to1` operand muxes feeding the ALU. Detects load-use hazards, stalls issue for one cycle and inserts a bubble. Sits between the decode stage and the ID/EX register; its select outputs drive `Sel` of the EX-stage operand muxes.

## Interface
Parameters:
- REG_W, 4, register-index width (2^REG_W architectural registers)
- ZERO_REG, 1, when 1 register index 0 is hardwired zero and never forwarded
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage presents an instruction
- id_rs1, id_rs2  in  REG_W  source register indices
- id_rd  in  REG_W  destination register index
- id_reg_write  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a memory load
- id_use_imm  in  1  operand B comes from the immediate
- flush  in  1  discard the instruction currently in decode (branch redirect)
- id_ready  out  1  decode may advance this cycle (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_sel_a, ex_sel_b  out  3  operand-mux select codes for the instruction in EX
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Select encoding (mux inputs D0..D5): 000 register file; 001 EX/MEM ALU result; 010 MEM/WB ALU result; 011 MEM/WB load data; 100 immediate; 101 WB retire latch. 110 and 111 are never produced.
- Shadow slots EX, MEM, WB each hold {valid, rd, reg_write, is_load}. Every cycle MEM←EX and WB←MEM, unconditionally.
- A producer slot P matches source rs when all of the following hold: P.valid, P.reg_write, P.rd == rs, and not (ZERO_REG and rs == 0).
- Select decision for each source, evaluated against the current slots while the instruction is in decode. Youngest producer wins:
  - Match in EX with is_load: load-use hazard (see below).
  - Match in EX, not a load: 001.
  - Else match in MEM: 011 if MEM.is_load, otherwise 010.
  - Else match in WB: 101.
  - Else: 000.
- Operand B: id_use_imm forces 100, and rs2 is then ignored for hazard detection.
- Hazard: hazard = id_valid & load-use match on rs1, or on rs2 when id_use_imm = 0. id_ready = ~hazard | flush.
- EX slot update, in priority order:
  - flush: bubble.
  - hazard: bubble, and stall_count increments.
  - id_valid: load ID fields, ex_sel_a and ex_sel_b.
  - otherwise: bubble.
- A bubble has valid = 0 and reg_write = 0, and sets ex_sel_a = ex_sel_b = 000.
- During a stall, decode holds the same instruction. Next cycle the load is in MEM, so the select resolves to 011.
- stall_count saturates at 2^CNT_W − 1 and never wraps.

## Timing
- Reset (rst high at a rising edge): all slots invalid; ex_valid = 0, ex_sel_a = ex_sel_b = 000, stall_count = 0. id_ready = 1 in the cycle after reset.
- Reset asserted mid-stall or mid-stream: all in-flight slots are dropped in the same edge. No forwarding codes refer to pre-reset producers.
- ex_sel_a, ex_sel_b and ex_valid are registered. They change on the edge that moves an instruction into EX and are valid for that instruction's whole EX cycle. Latency is one cycle from decode to select.
- id_ready is combinational from the ID inputs and the current slots. It has no registered delay.
- A load-use hazard costs exactly one stall cycle. Back-to-back dependent loads each cost one cycle.
- Flush and hazard in the same cycle: flush wins. A bubble is inserted, id_ready = 1 and stall_count does not increment.
- A WB-slot match overrides a stale register-file read. The register file is not write-through.

## Test plan
- Reset: hold rst for 2 cycles with id_valid = 1 -> ex_valid = 0, sels 000, stall_count = 0, id_ready = 1.
- ALU chain: issue add r3 (rd = 3), then sub rs1 = 3, rs2 = 3 -> sub in EX has ex_sel_a = ex_sel_b = 001. A third instruction with rs1 = 3 two slots later gets 010; three slots later gets 101; four slots later gets 000.
- Load-use: issue load r5, then add rs1 = 5 -> id_ready = 0 for one cycle and a bubble enters EX (ex_valid = 0). Next cycle the add enters EX with ex_sel_a = 011, and stall_count = 1.
- Immediate and zero register:
  - rs2 = 5 with id_use_imm = 1 behind load r5 -> no stall, ex_sel_b = 100.
  - Producer rd = 0 followed by a consumer with rs1 = 0, ZERO_REG = 1 -> ex_sel_a = 000.
- Flush with hazard: load r2, then a consumer with rs1 = 2 while flush = 1 -> id_ready = 1, EX bubble, stall_count unchanged.
- Counter saturation: with CNT_W = 2, force 5 load-use stalls -> stall_count holds at 3.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-to-execute control bundle for the forwarding/hazard block.
// The master side is the decode stage; the slave side is fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic             id_use_imm;
    logic             flush;
    logic             id_ready;
    logic             ex_valid;
    logic [2:0]       ex_sel_a;
    logic [2:0]       ex_sel_b;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load, id_use_imm, flush,
        input  id_ready, ex_valid, ex_sel_a, ex_sel_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load, id_use_imm, flush,
        output id_ready, ex_valid, ex_sel_a, ex_sel_b, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Execute-stage forwarding select generation and load-use stall control,
// driven by a 3-deep shadow of in-flight destination registers (EX/MEM/WB).
module fwd_hazard_ctrl #(
    parameter int REG_W    = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input logic             clk,
    input logic             rst,
    fwd_hazard_ctrl_if.slave bus
);
    localparam logic [2:0] SEL_RF   = 3'b000;
    localparam logic [2:0] SEL_EXM  = 3'b001;
    localparam logic [2:0] SEL_MWA  = 3'b010;
    localparam logic [2:0] SEL_MWL  = 3'b011;
    localparam logic [2:0] SEL_IMM  = 3'b100;
    localparam logic [2:0] SEL_WB   = 3'b101;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             is_load;
    } slot_t;

    slot_t            ex_slot, mem_slot, wb_slot;
    logic [2:0]       sel_a_q, sel_b_q;
    logic [CNT_W-1:0] stall_cnt;

    logic [2:0] sel_a, sel_b, sel_b_reg;
    logic       ld_a, ld_b, hazard;

    function automatic logic hit(input slot_t s, input logic [REG_W-1:0] rs);
        return s.valid && s.reg_write && (s.rd == rs) && !(ZERO_REG && (rs == '0));
    endfunction

    // Youngest producer wins; a load still in EX cannot forward yet.
    function automatic logic [3:0] resolve(input slot_t ex_s, input slot_t mem_s,
                                           input slot_t wb_s, input logic [REG_W-1:0] rs);
        logic [3:0] r;
        r = {1'b0, SEL_RF};
        if (hit(ex_s, rs))       r = ex_s.is_load ? {1'b1, SEL_RF} : {1'b0, SEL_EXM};
        else if (hit(mem_s, rs)) r = {1'b0, mem_s.is_load ? SEL_MWL : SEL_MWA};
        else if (hit(wb_s, rs))  r = {1'b0, SEL_WB};
        return r;
    endfunction

    always_comb begin
        {ld_a, sel_a}     = resolve(ex_slot, mem_slot, wb_slot, bus.id_rs1);
        {ld_b, sel_b_reg} = resolve(ex_slot, mem_slot, wb_slot, bus.id_rs2);
        sel_b  = bus.id_use_imm ? SEL_IMM : sel_b_reg;
        hazard = bus.id_valid && (ld_a || (ld_b && !bus.id_use_imm));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            sel_a_q   <= SEL_RF;
            sel_b_q   <= SEL_RF;
            stall_cnt <= '0;
        end else begin
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
            if (bus.flush || hazard || !bus.id_valid) begin
                ex_slot <= '0;
                sel_a_q <= SEL_RF;
                sel_b_q <= SEL_RF;
            end else begin
                ex_slot <= '{valid: 1'b1, rd: bus.id_rd,
                             reg_write: bus.id_reg_write, is_load: bus.id_is_load};
                sel_a_q <= sel_a;
                sel_b_q <= sel_b;
            end
            if (!bus.flush && hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.id_ready    = !hazard || bus.flush;
    assign bus.ex_valid    = ex_slot.valid;
    assign bus.ex_sel_a    = sel_a_q;
    assign bus.ex_sel_b    = sel_b_q;
    assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with a scoreboard of expected EX-stage results.
module tb_fwd_hazard_ctrl;
    localparam int REG_W = 4;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic       v;
        logic [2:0] a;
        logic [2:0] b;
    } exp_t;
    exp_t sb[$];

    fwd_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.REG_W(REG_W), .ZERO_REG(1'b1), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic rw, input logic ld,
                         input logic imm, input logic fl);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_is_load   = ld;
        bus.id_use_imm   = imm;
        bus.flush        = fl;
    endtask

    // Drive one decode cycle, check id_ready before the edge, check EX after it.
    task automatic issue(input string tag, input logic v, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [3:0] rd, input logic rw,
                         input logic ld, input logic imm, input logic fl, input logic rdy,
                         input logic ev, input logic [2:0] ea, input logic [2:0] eb);
        exp_t e;
        drive(v, rs1, rs2, rd, rw, ld, imm, fl);
        sb.push_back('{v: ev, a: ea, b: eb});
        #1;
        chk({tag, ".id_ready"}, 16'(bus.id_ready), 16'(rdy));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".ex_valid"}, 16'(bus.ex_valid), 16'(e.v));
        chk({tag, ".ex_sel_a"}, 16'(bus.ex_sel_a), 16'(e.a));
        chk({tag, ".ex_sel_b"}, 16'(bus.ex_sel_b), 16'(e.b));
    endtask

    initial begin
        logic [CNT_W-1:0] exp_cnt;
        drive(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ex_valid", 16'(bus.ex_valid), 16'd0);
        chk("rst.ex_sel_a", 16'(bus.ex_sel_a), 16'd0);
        chk("rst.ex_sel_b", 16'(bus.ex_sel_b), 16'd0);
        chk("rst.stall_count", 16'(bus.stall_count), 16'd0);
        rst = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst.id_ready", 16'(bus.id_ready), 16'd1);

        // ALU chain on r3
        issue("add_r3",  1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 0, 1, 1, 3'b000, 3'b000);
        issue("sub_ex",  1, 4'd3, 4'd3, 4'd4, 1, 0, 0, 0, 1, 1, 3'b001, 3'b001);
        issue("use_mem", 1, 4'd3, 4'd0, 4'd6, 1, 0, 0, 0, 1, 1, 3'b010, 3'b000);
        issue("use_wb",  1, 4'd3, 4'd1, 4'd7, 1, 0, 0, 0, 1, 1, 3'b101, 3'b000);
        issue("use_rf",  1, 4'd3, 4'd1, 4'd0, 0, 0, 0, 0, 1, 1, 3'b000, 3'b000);

        // Load-use stall
        issue("ld_r5",     1, 4'd1, 4'd2, 4'd5, 1, 1, 1, 0, 1, 1, 3'b000, 3'b100);
        issue("lu_stall",  1, 4'd5, 4'd7, 4'd8, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        chk("lu.stall_count", 16'(bus.stall_count), 16'd1);
        issue("lu_resume", 1, 4'd5, 4'd7, 4'd8, 1, 0, 0, 0, 1, 1, 3'b011, 3'b000);
        chk("lu.stall_count_hold", 16'(bus.stall_count), 16'd1);

        // Immediate masks rs2; zero register is never forwarded
        issue("ld_r5b",   1, 4'd0, 4'd0, 4'd5, 1, 1, 1, 0, 1, 1, 3'b000, 3'b100);
        issue("imm_nost", 1, 4'd1, 4'd5, 4'd9, 1, 0, 1, 0, 1, 1, 3'b000, 3'b100);
        chk("imm.stall_count", 16'(bus.stall_count), 16'd1);
        issue("wr_r0",    1, 4'd1, 4'd1, 4'd0, 1, 0, 0, 0, 1, 1, 3'b000, 3'b000);
        issue("rd_r0",    1, 4'd0, 4'd9, 4'd10, 1, 0, 0, 0, 1, 1, 3'b000, 3'b010);

        // Flush beats hazard
        issue("ld_r2",    1, 4'd1, 4'd1, 4'd2, 1, 1, 0, 0, 1, 1, 3'b000, 3'b000);
        issue("flush_hz", 1, 4'd2, 4'd0, 4'd0, 0, 0, 0, 1, 1, 0, 3'b000, 3'b000);
        chk("flush.stall_count", 16'(bus.stall_count), 16'd1);
        issue("idle",     0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, 3'b000, 3'b000);

        // Five more stalls: the 2-bit counter must pin at 3
        exp_cnt = 2'd1;
        for (int i = 0; i < 5; i++) begin
            issue("sat_ld",    1, 4'd0, 4'd0, 4'd11, 1, 1, 0, 0, 1, 1, 3'b000, 3'b000);
            issue("sat_stall", 1, 4'd11, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
            exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
            chk("sat.stall_count", 16'(bus.stall_count), 16'(exp_cnt));
            issue("sat_go",    1, 4'd11, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, 3'b011, 3'b000);
        end

        // Reset mid-stall drops the in-flight load
        issue("ld_r12", 1, 4'd0, 4'd0, 4'd12, 1, 1, 0, 0, 1, 1, 3'b000, 3'b000);
        drive(1'b1, 4'd12, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mid.id_ready_pre", 16'(bus.id_ready), 16'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.ex_valid", 16'(bus.ex_valid), 16'd0);
        chk("mid.stall_count", 16'(bus.stall_count), 16'd0);
        rst = 1'b0;
        issue("post_rst", 1, 4'd12, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, 3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
